// File: rtl/ahblite_rect_fill_if.sv
// AHB-Lite slave-side bus bundle for the rectangle-fill engine.
// Signal names follow the AMBA AHB-Lite naming so the decoder hookup stays obvious.
interface ahblite_rect_fill_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahblite_rect_fill.sv
// AHB-Lite slave that queues rectangle-fill commands and expands each one into
// H single-row writes of W pixels on the display controller's row-write port.
module ahblite_rect_fill #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_LSB_W = 5
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahblite_rect_fill_if.slave  bus,
  output logic [15:0]         X_POS,
  output logic [15:0]         Y_POS,
  output logic [23:0]         PIXEL,
  output logic [23:0]         LEN,
  output logic                ENABLE,
  input  logic                BUSY,
  output logic                IRQ
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = ADDR_LSB_W - 2;

  localparam logic [IDX_W-1:0] REG_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] REG_ORG    = IDX_W'(1);
  localparam logic [IDX_W-1:0] REG_SIZE   = IDX_W'(2);
  localparam logic [IDX_W-1:0] REG_COLOR  = IDX_W'(3);
  localparam logic [IDX_W-1:0] REG_PUSH   = IDX_W'(4);
  localparam logic [IDX_W-1:0] REG_STATUS = IDX_W'(5);

  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] w;
    logic [15:0] h;
    logic [23:0] color;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_ACK, S_DONE} state_t;

  // Bus-side state
  logic             r_dphase;
  logic             r_write;
  logic [IDX_W-1:0] r_idx;
  logic             r_ie;
  logic             r_ovf;
  logic [31:0]      r_org;
  logic [31:0]      r_size;
  logic [23:0]      r_color;

  // Command FIFO
  cmd_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  // Engine
  state_t           r_state;
  state_t           w_state_nxt;
  cmd_t             r_cmd;
  logic [15:0]      r_row;
  logic             r_enable;
  logic [15:0]      r_x_pos;
  logic [15:0]      r_y_pos;
  logic [23:0]      r_pixel;
  logic [23:0]      r_len;
  logic             r_irq;

  logic             w_addr_phase;
  logic             w_wr;
  logic             w_full;
  logic             w_empty;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_emit;
  logic             w_row_adv;
  logic             w_last_row;
  logic             w_active;
  logic [31:0]      w_rdata;
  cmd_t             w_new_cmd;
  logic             w_unused;

  assign w_addr_phase = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign w_wr         = r_dphase & r_write & bus.HREADY;
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push_req   = w_wr & (r_idx == REG_PUSH);
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign w_push       = w_push_req & (~w_full | w_pop);
  assign w_active     = (r_state != S_IDLE);
  assign w_last_row   = ((r_row + 16'd1) == r_cmd.h);
  assign w_new_cmd    = '{x0: r_org[15:0], y0: r_org[31:16],
                          w: r_size[15:0], h: r_size[31:16], color: r_color};
  assign w_unused     = ^{bus.HSIZE, bus.HTRANS[0], bus.HADDR[31:ADDR_LSB_W], bus.HADDR[1:0]};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dphase <= 1'b0;
      r_write  <= 1'b0;
      r_idx    <= '0;
    end else if (bus.HREADY) begin
      r_dphase <= w_addr_phase;
      r_write  <= bus.HWRITE;
      r_idx    <= bus.HADDR[ADDR_LSB_W-1:2];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ie    <= 1'b0;
      r_ovf   <= 1'b0;
      r_org   <= '0;
      r_size  <= '0;
      r_color <= '0;
    end else begin
      if (w_push_req && !w_push) begin
        r_ovf <= 1'b1;
      end else if (w_wr && r_idx == REG_CTRL && bus.HWDATA[1]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr) begin
        unique case (r_idx)
          REG_CTRL:  r_ie    <= bus.HWDATA[0];
          REG_ORG:   r_org   <= bus.HWDATA;
          REG_SIZE:  r_size  <= bus.HWDATA;
          REG_COLOR: r_color <= bus.HWDATA[23:0];
          default:   ;
        endcase
      end
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wptr] <= w_new_cmd;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_emit      = 1'b0;
    w_row_adv   = 1'b0;
    unique case (r_state)
      S_IDLE:  if (!w_empty) begin
                 w_pop       = 1'b1;
                 w_state_nxt = S_CHECK;
               end
      S_CHECK: w_state_nxt = (r_cmd.w == '0 || r_cmd.h == '0) ? S_IDLE : S_ISSUE;
      S_ISSUE: if (!BUSY) begin
                 w_emit      = 1'b1;
                 w_state_nxt = S_ACK;
               end
      S_ACK:   if (BUSY) w_state_nxt = S_DONE;
      S_DONE:  if (!BUSY) begin
                 w_row_adv   = 1'b1;
                 w_state_nxt = w_last_row ? S_IDLE : S_ISSUE;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_cmd    <= '0;
      r_row    <= '0;
      r_enable <= 1'b0;
      r_x_pos  <= '0;
      r_y_pos  <= '0;
      r_pixel  <= '0;
      r_len    <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_enable <= w_emit;
      r_irq    <= r_ie & w_empty & (r_state == S_IDLE);
      if (w_pop) begin
        r_cmd <= r_mem[r_rptr];
        r_row <= '0;
      end else if (w_row_adv) begin
        r_row <= r_row + 16'd1;
      end
      // Row coordinates are latched with ENABLE and held until the next row issues.
      if (w_emit) begin
        r_x_pos <= r_cmd.x0;
        r_y_pos <= r_cmd.y0 + r_row;
        r_len   <= {8'b0, r_cmd.w};
        r_pixel <= r_cmd.color;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_dphase && !r_write) begin
      unique case (r_idx)
        REG_CTRL:   w_rdata = {30'b0, r_ovf, r_ie};
        REG_ORG:    w_rdata = r_org;
        REG_SIZE:   w_rdata = r_size;
        REG_COLOR:  w_rdata = {8'b0, r_color};
        REG_STATUS: w_rdata = {21'b0, r_ovf, w_full, w_active, 8'(r_count)};
        default:    w_rdata = '0;
      endcase
    end
  end

  assign bus.HRDATA    = w_rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  assign X_POS  = r_x_pos;
  assign Y_POS  = r_y_pos;
  assign PIXEL  = r_pixel;
  assign LEN    = r_len;
  assign ENABLE = r_enable;
  assign IRQ    = r_irq;

endmodule
